// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register word indices (PADDR[4:2]), size limits and APB request/response types
// shared by irq_ctrl and its users.
package irq_ctrl_pkg;

  localparam int IRQ_MAX = 32;
  localparam int ID_W    = 6;

  // Word index within the 32-byte window; byte offset = index * 4.
  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_CLAIM   = 3'd2,
    REG_GIE     = 3'd3,
    REG_EDGE    = 3'd4
  } reg_idx_e;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
  } apb_rsp_t;

endpackage

// File: rtl/irq_ctrl_sync.sv
// irq_sync: two-flop synchronizer for one interrupt source plus rising-edge detect.
// The sync_d flop and edge detect are built only when IRQ_CTRL_EDGE_EN is defined.
module irq_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic sync_o,
  output logic rise_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= irq_i;
      r_sync <= r_meta;
    end
  end

  assign sync_o = r_sync;

`ifdef IRQ_CTRL_EDGE_EN
  logic r_sync_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync_d <= 1'b0;
    end else begin
      r_sync_d <= r_sync;
    end
  end

  assign rise_o = r_sync & ~r_sync_d;
`else
  assign rise_o = 1'b0;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: APB interrupt controller with pending/enable/claim/global-enable registers.
// Define IRQ_CTRL_EDGE_EN to add the EDGE register and per-source edge-triggered mode.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQS = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_IRQS-1:0] irq_i,
  output logic              irq_o,
  input  apb_req_t          apb_bus_i,
  output apb_rsp_t          apb_bus_o
);

  logic [N_IRQS-1:0] w_sync;
  logic [N_IRQS-1:0] w_rise;
  logic [N_IRQS-1:0] w_active;
  logic [N_IRQS-1:0] w_claim_oh;
  logic [N_IRQS-1:0] w_pend_next;
  logic [N_IRQS-1:0] w_edge_rd;
  logic [N_IRQS-1:0] r_pending;
  logic [N_IRQS-1:0] r_enable;
  logic              r_gie;
  logic              r_irq;
  logic [ID_W-1:0]   w_claim_id;
  logic [2:0]        w_idx;
  logic              w_wr;
  logic              w_rd;
  logic [31:0]       w_rdata;
  logic              w_unused_bits;

  generate
    for (genvar gi = 0; gi < N_IRQS; gi++) begin : g_sync
      irq_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .irq_i  (irq_i[gi]),
        .sync_o (w_sync[gi]),
        .rise_o (w_rise[gi])
      );
    end
  endgenerate

  assign w_idx    = apb_bus_i.paddr[4:2];
  assign w_wr     = apb_bus_i.psel & apb_bus_i.penable & apb_bus_i.pwrite;
  assign w_rd     = apb_bus_i.psel & apb_bus_i.penable & ~apb_bus_i.pwrite;
  assign w_active = r_pending & r_enable;

  // Scan high-to-low so the lowest active index is the one left standing.
  always_comb begin
    w_claim_id = '0;
    w_claim_oh = '0;
    for (int i = N_IRQS - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_claim_id    = ID_W'(i + 1);
        w_claim_oh    = '0;
        w_claim_oh[i] = 1'b1;
      end
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_IRQS-1:0] r_edge;
  logic [N_IRQS-1:0] w_clr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_edge <= '0;
    end else if (w_wr && (w_idx == REG_EDGE)) begin
      r_edge <= apb_bus_i.pwdata[N_IRQS-1:0];
    end
  end

  assign w_clr = ((w_wr && (w_idx == REG_PENDING)) ? apb_bus_i.pwdata[N_IRQS-1:0] : '0)
               | ((w_rd && (w_idx == REG_CLAIM)) ? w_claim_oh : '0);

  // A new edge in the same cycle as a clear keeps the source pending.
  assign w_pend_next = (r_edge & ((r_pending & ~w_clr) | w_rise)) | (~r_edge & w_sync);
  assign w_edge_rd   = r_edge;
`else
  logic w_unused_edge;

  assign w_pend_next   = w_sync;
  assign w_edge_rd     = '0;
  assign w_unused_edge = ^{w_rise, w_claim_oh};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_gie     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      if (w_wr && (w_idx == REG_ENABLE)) begin
        r_enable <= apb_bus_i.pwdata[N_IRQS-1:0];
      end
      if (w_wr && (w_idx == REG_GIE)) begin
        r_gie <= apb_bus_i.pwdata[0];
      end
      r_irq <= r_gie & (|w_active);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd && !rst_i) begin
      case (w_idx)
        REG_PENDING: w_rdata[N_IRQS-1:0] = r_pending;
        REG_ENABLE:  w_rdata[N_IRQS-1:0] = r_enable;
        REG_CLAIM:   w_rdata[ID_W-1:0]   = w_claim_id;
        REG_GIE:     w_rdata[0]          = r_gie;
        REG_EDGE:    w_rdata[N_IRQS-1:0] = w_edge_rd;
        default:     w_rdata             = '0;
      endcase
    end
  end

  assign irq_o            = r_irq;
  assign apb_bus_o.prdata = w_rdata;
  assign apb_bus_o.pready = ~rst_i;

  assign w_unused_bits = ^{apb_bus_i.paddr[31:5], apb_bus_i.paddr[1:0], apb_bus_i.pwdata};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and randomized checks of irq_ctrl against a cycle-level behavioural model.
// Edge-mode scenarios are included when IRQ_CTRL_EDGE_EN is defined.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 10;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] irq_i = '0;
  logic         irq_o;
  apb_req_t     apb_req = '0;
  apb_rsp_t     apb_rsp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  irq_ctrl #(.N_IRQS(N)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_i     (irq_i),
    .irq_o     (irq_o),
    .apb_bus_i (apb_req),
    .apb_bus_o (apb_rsp)
  );

  // Reference model: the synchronized value of a source is its input two clock samples back.
  logic [N-1:0] m_pend, m_en, m_edge, m_s1, m_s2, m_s3, m_clr;
  logic         m_gie, m_irq;
  int           m_id;

  function automatic int lowest_id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i + 1;
    end
    return 0;
  endfunction

  always_comb begin
    m_clr = '0;
    m_id  = lowest_id(m_pend & m_en);
    if (apb_req.psel && apb_req.penable) begin
      if (apb_req.pwrite && apb_req.paddr[4:2] == 3'd0) m_clr = apb_req.pwdata[N-1:0];
      if (!apb_req.pwrite && apb_req.paddr[4:2] == 3'd2 && m_id != 0) m_clr[m_id-1] = 1'b1;
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_pend <= '0; m_en <= '0; m_edge <= '0; m_gie <= 1'b0; m_irq <= 1'b0;
      m_s1 <= '0; m_s2 <= '0; m_s3 <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_edge[i]) m_pend[i] <= (m_s2[i] && !m_s3[i]) || (m_pend[i] && !m_clr[i]);
        else           m_pend[i] <= m_s2[i];
      end
      m_irq <= m_gie && ((m_pend & m_en) != '0);
      if (apb_req.psel && apb_req.penable && apb_req.pwrite) begin
        if (apb_req.paddr[4:2] == 3'd1) m_en  <= apb_req.pwdata[N-1:0];
        if (apb_req.paddr[4:2] == 3'd3) m_gie <= apb_req.pwdata[0];
`ifdef IRQ_CTRL_EDGE_EN
        if (apb_req.paddr[4:2] == 3'd4) m_edge <= apb_req.pwdata[N-1:0];
`endif
      end
      m_s3 <= m_s2;
      m_s2 <= m_s1;
      m_s1 <= irq_i;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] idx);
    logic [31:0] v;
    v = '0;
    case (idx)
      3'd0: v[N-1:0] = m_pend;
      3'd1: v[N-1:0] = m_en;
      3'd2: v = 32'(lowest_id(m_pend & m_en));
      3'd3: v[0] = m_gie;
      3'd4: v[N-1:0] = m_edge;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    chk("irq_o_model", {31'b0, irq_o}, {31'b0, m_irq});
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    apb_req.paddr = a; apb_req.pwdata = d; apb_req.pwrite = 1'b1;
    apb_req.psel = 1'b1; apb_req.penable = 1'b0;
    tick();
    apb_req.penable = 1'b1;
    #1;
    chk("pready_wr", {31'b0, apb_rsp.pready}, 32'd1);
    tick();
    apb_req.psel = 1'b0; apb_req.penable = 1'b0; apb_req.pwrite = 1'b0;
    $display("APB wr addr=0x%02h data=0x%08h", a[7:0], d);
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    apb_req.paddr = a; apb_req.pwrite = 1'b0;
    apb_req.psel = 1'b1; apb_req.penable = 1'b0;
    tick();
    apb_req.penable = 1'b1;
    #1;
    d = apb_rsp.prdata;
    chk("pready_rd", {31'b0, apb_rsp.pready}, 32'd1);
    chk($sformatf("rd_model_0x%02h", a[7:0]), d, exp_rd(a[4:2]));
    tick();
    apb_req.psel = 1'b0; apb_req.penable = 1'b0;
    $display("APB rd addr=0x%02h data=0x%08h", a[7:0], d);
  endtask

  initial begin
    logic [31:0] d;
    int op;

    // Power-on reset
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_irq_o", {31'b0, irq_o}, 32'd0);
    chk("rst_pready", {31'b0, apb_rsp.pready}, 32'd0);
    rst_i = 1'b0;
    tick();
    apb_rd(32'h04, d); chk("rst_enable", d, 32'd0);
    apb_rd(32'h0C, d); chk("rst_gie", d, 32'd0);
    apb_rd(32'h08, d); chk("rst_claim", d, 32'd0);

    // Latency: three edges after the sampling edge, both directions
    apb_wr(32'h04, 32'h001);
    apb_wr(32'h0C, 32'h1);
    irq_i[0] = 1'b1;
    tick(); chk("lat_rise_e0", {31'b0, irq_o}, 32'd0);
    tick(); chk("lat_rise_e1", {31'b0, irq_o}, 32'd0);
    tick(); chk("lat_rise_e2", {31'b0, irq_o}, 32'd0);
    tick(); chk("lat_rise_e3", {31'b0, irq_o}, 32'd1);
    irq_i[0] = 1'b0;
    tick(); chk("lat_fall_e0", {31'b0, irq_o}, 32'd1);
    tick(); chk("lat_fall_e1", {31'b0, irq_o}, 32'd1);
    tick(); chk("lat_fall_e2", {31'b0, irq_o}, 32'd1);
    tick(); chk("lat_fall_e3", {31'b0, irq_o}, 32'd0);

    // Mask: level source 2, gated by GIE and ENABLE
    irq_i = 10'h004;
    apb_wr(32'h0C, 32'h0);
    apb_wr(32'h04, 32'h004);
    repeat (4) tick();
    chk("mask_gie0", {31'b0, irq_o}, 32'd0);
    apb_rd(32'h00, d); chk("mask_pending", d, 32'h004);
    apb_rd(32'h08, d); chk("level_claim", d, 32'd3);
    apb_wr(32'h00, 32'h004);
    apb_rd(32'h00, d); chk("level_unaffected", d, 32'h004);
    apb_wr(32'h0C, 32'h1);
    chk("mask_gie1_e0", {31'b0, irq_o}, 32'd0);
    tick(); chk("mask_gie1_e1", {31'b0, irq_o}, 32'd1);
    apb_wr(32'h04, 32'h0);
    chk("mask_en0_e0", {31'b0, irq_o}, 32'd1);
    tick(); chk("mask_en0_e1", {31'b0, irq_o}, 32'd0);
    apb_rd(32'h08, d); chk("mask_claim", d, 32'd0);

    // Decode of unmapped offsets
    apb_wr(32'h04, 32'h155);
    apb_rd(32'h14, d); chk("unmapped_14", d, 32'd0);
    apb_rd(32'h18, d); chk("unmapped_18", d, 32'd0);
    apb_rd(32'h1C, d); chk("unmapped_1c", d, 32'd0);
    apb_wr(32'h14, 32'hFFFF_FFFF);
    apb_rd(32'h04, d); chk("decode_enable", d, 32'h155);
    apb_rd(32'h0C, d); chk("decode_gie", d, 32'h1);
    apb_wr(32'h10, 32'h3FF);
    apb_rd(32'h10, d);
`ifdef IRQ_CTRL_EDGE_EN
    chk("edge_rw", d, 32'h3FF);
    apb_wr(32'h10, 32'h0);
`else
    chk("edge_absent", d, 32'h0);
`endif

    // Asynchronous reset with all sources high and ENABLE loaded
    irq_i = 10'h3FF;
    apb_wr(32'h04, 32'h3FF);
    repeat (4) tick();
    chk("pre_rst_irq_o", {31'b0, irq_o}, 32'd1);
    apb_req.paddr = 32'h04; apb_req.pwrite = 1'b0; apb_req.psel = 1'b1; apb_req.penable = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_irq_o", {31'b0, irq_o}, 32'd0);
    chk("arst_pready", {31'b0, apb_rsp.pready}, 32'd0);
    chk("arst_prdata", apb_rsp.prdata, 32'd0);
    apb_req.psel = 1'b0; apb_req.penable = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    apb_rd(32'h04, d); chk("arst_enable", d, 32'd0);
    apb_rd(32'h0C, d); chk("arst_gie", d, 32'd0);
    apb_rd(32'h10, d); chk("arst_edge", d, 32'd0);
`ifdef IRQ_CTRL_EDGE_EN
    repeat (4) tick();
    apb_wr(32'h10, 32'h3FF);
    apb_wr(32'h00, 32'h3FF);
    apb_rd(32'h00, d); chk("arst_no_edge", d, 32'h0);

    // Claim priority on edge sources 5 and 2
    irq_i = '0;
    apb_wr(32'h04, 32'h3FF);
    apb_wr(32'h0C, 32'h1);
    irq_i = 10'h024;
    repeat (2) tick();
    irq_i = '0;
    repeat (4) tick();
    apb_rd(32'h08, d); chk("claim_first", d, 32'd3);
    apb_rd(32'h08, d); chk("claim_second", d, 32'd6);
    tick(); chk("claim_irq_low", {31'b0, irq_o}, 32'd0);
    apb_rd(32'h08, d); chk("claim_none", d, 32'd0);
    apb_rd(32'h00, d); chk("claim_pending", d, 32'h0);

    // W1C colliding with a new edge on source 4
    irq_i[4] = 1'b1;
    repeat (2) tick();
    irq_i[4] = 1'b0;
    repeat (4) tick();
    irq_i[4] = 1'b1;
    tick();
    apb_wr(32'h00, 32'h010);
    apb_rd(32'h00, d); chk("w1c_collide", d, 32'h010);
    apb_wr(32'h00, 32'h010);
    apb_rd(32'h00, d); chk("w1c_clear", d, 32'h0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      op = int'($urandom_range(0, 5));
      if (op == 0) begin
        irq_i = N'($urandom);
        tick();
      end else if (op == 1) begin
        apb_wr({27'b0, 3'($urandom_range(0, 7)), 2'b00}, $urandom);
      end else if (op == 2) begin
        apb_wr(32'h0C, {31'b0, 1'($urandom)});
      end else begin
        apb_rd({27'b0, 3'($urandom_range(0, 7)), 2'b00}, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
